// File: rtl/riscv_proc_mul_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscv_proc_mul_issue_ctrl_pkg
//
// Shared constants and types for the multiplier issue/writeback controller:
//   IMUL_STAGES  - default multiplier latency in cycles
//   REG_AW       - architectural register address width
//   NUM_REGS     - number of architectural registers
//   drain_state_e- drain FSM state encodings (RUN / DRAIN / DONE)
//   WB_SEL_*     - register-file write-data mux select encodings
//   reg_onehot() - one-hot decode of a register address
// -----------------------------------------------------------------------------
package riscv_proc_mul_issue_ctrl_pkg;

    localparam int IMUL_STAGES = 3;
    localparam int REG_AW      = 5;
    localparam int NUM_REGS    = 1 << REG_AW;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_e;

    localparam logic WB_SEL_MUL = 1'b0;
    localparam logic WB_SEL_DIV = 1'b1;

    // One-hot decode used to build scoreboard set/clear masks.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] addr);
        logic [NUM_REGS-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage : riscv_proc_mul_issue_ctrl_pkg

// File: rtl/riscv_proc_mul_scoreboard.sv
// -----------------------------------------------------------------------------
// riscv_proc_mul_scoreboard
//
// One pending bit per architectural register, tracking destinations of
// multiplies that have issued but not yet written back.
//
// Ports:
//   clk, reset_n           - clock, asynchronous active-low reset
//   set_en, set_addr       - mark a destination pending (x0 is ignored)
//   clr_en, clr_addr       - clear a destination on writeback
//   rd_addr1..3            - three independent read addresses
//   rd_pend1..3            - registered pending bit for each read address
// -----------------------------------------------------------------------------
module riscv_proc_mul_scoreboard
    import riscv_proc_mul_issue_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_addr,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_addr,
    input  logic [REG_AW-1:0] rd_addr1,
    input  logic [REG_AW-1:0] rd_addr2,
    input  logic [REG_AW-1:0] rd_addr3,
    output logic              rd_pend1,
    output logic              rd_pend2,
    output logic              rd_pend3
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // NOTE: every signal written in an always_comb gets a value on every path
    // (defaults first); otherwise synthesis infers a latch.
    always_comb begin
        set_mask  = set_en ? reg_onehot(set_addr) : '0;
        clr_mask  = clr_en ? reg_onehot(clr_addr) : '0;
        // Set is applied after clear so a same-cycle set/clear leaves the bit set.
        pending_d    = (pending_q & ~clr_mask) | set_mask;
        // x0 is hardwired to zero and must never stall.
        pending_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rd_pend1 = pending_q[rd_addr1];
    assign rd_pend2 = pending_q[rd_addr2];
    assign rd_pend3 = pending_q[rd_addr3];

endmodule : riscv_proc_mul_scoreboard

// File: rtl/riscv_proc_mul_issue_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_proc_mul_issue_ctrl
//
// Issue and writeback controller for the fixed-latency integer multiplier.
// Stalls decode on RAW/WAW hazards against in-flight multiplies, fires the
// multiplier, arbitrates the single register-file write port (multiplier
// results win over divider results), and offers a drain handshake that
// quiesces the multiplier before a flush or exception.
//
// Parameters:
//   STAGES           - multiplier latency in cycles (>= 1)
//
// Ports:
//   clk, reset_n                 - clock, asynchronous active-low reset
//   req_val/req_waddr/req_raddr* - multiply request from decode
//   req_ren1/req_ren2            - source operand actually read
//   req_rdy                      - request may issue this cycle (indep. of req_val)
//   mul_fire, mul_waddr          - multiplier launch and destination
//   mul_result_val/_tag          - multiplier writeback
//   div_wb_val/_tag, div_wb_rdy  - divider writeback handshake
//   wb_val, wb_waddr, wb_sel     - register-file write port and data select
//   drain_req, drain_done        - level drain request / quiesced indication
//   busy                         - at least one multiply in flight
// -----------------------------------------------------------------------------
module riscv_proc_mul_issue_ctrl
    import riscv_proc_mul_issue_ctrl_pkg::*;
#(
    parameter int STAGES = IMUL_STAGES
)
(
    input  logic              clk,
    input  logic              reset_n,

    input  logic              req_val,
    input  logic [REG_AW-1:0] req_waddr,
    input  logic [REG_AW-1:0] req_raddr1,
    input  logic [REG_AW-1:0] req_raddr2,
    input  logic              req_ren1,
    input  logic              req_ren2,
    output logic              req_rdy,

    output logic              mul_fire,
    output logic [REG_AW-1:0] mul_waddr,
    input  logic              mul_result_val,
    input  logic [REG_AW-1:0] mul_result_tag,

    input  logic              div_wb_val,
    input  logic [REG_AW-1:0] div_wb_tag,
    output logic              div_wb_rdy,

    output logic              wb_val,
    output logic [REG_AW-1:0] wb_waddr,
    output logic              wb_sel,

    input  logic              drain_req,
    output logic              drain_done,
    output logic              busy
);

    // At most one issue per cycle and STAGES cycles of latency bound the
    // in-flight count to STAGES.
    localparam int CNT_W = (STAGES < 1) ? 1 : $clog2(STAGES + 1);

    drain_state_e     state_q, state_d;
    logic             drain_done_q, drain_done_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;

    logic pend_rs1, pend_rs2, pend_rd;
    logic hazard;

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    riscv_proc_mul_scoreboard u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_en   (mul_fire),
        .set_addr (req_waddr),
        .clr_en   (mul_result_val),
        .clr_addr (mul_result_tag),
        .rd_addr1 (req_raddr1),
        .rd_addr2 (req_raddr2),
        .rd_addr3 (req_waddr),
        .rd_pend1 (pend_rs1),
        .rd_pend2 (pend_rs2),
        .rd_pend3 (pend_rd)
    );

    // -------------------------------------------------------------------------
    // Hazard check and issue. Only the registered pending bits are used: a
    // result writing back this cycle does not release a dependent request
    // until the following cycle.
    // -------------------------------------------------------------------------
    assign hazard    = (req_ren1 & pend_rs1) | (req_ren2 & pend_rs2) | pend_rd;
    assign req_rdy   = ~hazard & (state_q == RUN) & ~drain_req;
    assign mul_fire  = req_val & req_rdy;
    assign mul_waddr = req_waddr;

    // -------------------------------------------------------------------------
    // In-flight counter
    // -------------------------------------------------------------------------
    always_comb begin
        inflight_d = inflight_q;
        if (mul_fire && !mul_result_val) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!mul_fire && mul_result_val) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    assign busy = (inflight_q != '0);

    // -------------------------------------------------------------------------
    // Writeback arbitration: the multiplier cannot be back-pressured, so it
    // always wins; the divider holds its result until div_wb_rdy.
    // -------------------------------------------------------------------------
    always_comb begin
        if (mul_result_val) begin
            wb_val     = 1'b1;
            wb_waddr   = mul_result_tag;
            wb_sel     = WB_SEL_MUL;
            div_wb_rdy = 1'b0;
        end else begin
            wb_val     = div_wb_val;
            wb_waddr   = div_wb_tag;
            wb_sel     = WB_SEL_DIV;
            div_wb_rdy = div_wb_val;
        end
    end

    // -------------------------------------------------------------------------
    // Drain FSM. DRAIN looks at the registered in-flight count, so drain_done
    // rises the cycle after DRAIN sees the multiplier empty. drain_done is a
    // registered copy of "next state is DONE".
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (drain_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (!drain_req)               state_d = RUN;
                else if (inflight_q == '0)    state_d = DONE;
            end
            DONE: begin
                if (!drain_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        drain_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            drain_done_q <= 1'b0;
            inflight_q   <= '0;
        end else begin
            state_q      <= state_d;
            drain_done_q <= drain_done_d;
            inflight_q   <= inflight_d;
        end
    end

    assign drain_done = drain_done_q;

endmodule : riscv_proc_mul_issue_ctrl

// File: tb/tb_riscv_proc_mul_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_riscv_proc_mul_issue_ctrl
//
// Self-checking bench: a behavioural fixed-latency multiplier feeds results
// back to the controller; every fired destination is queued with its due
// cycle and matched against multiplier writebacks. A vector table exercises
// hazard detection and divider writeback, and hand-written sequences cover
// reset, stall timing, arbitration and drain.
// -----------------------------------------------------------------------------
module tb_riscv_proc_mul_issue_ctrl;
    import riscv_proc_mul_issue_ctrl_pkg::*;

    localparam int STAGES = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_val;
    logic [4:0] req_waddr, req_raddr1, req_raddr2;
    logic       req_ren1, req_ren2;
    logic       req_rdy;
    logic       mul_fire;
    logic [4:0] mul_waddr;
    logic       mul_result_val;
    logic [4:0] mul_result_tag;
    logic       div_wb_val;
    logic [4:0] div_wb_tag;
    logic       div_wb_rdy;
    logic       wb_val;
    logic [4:0] wb_waddr;
    logic       wb_sel;
    logic       drain_req;
    logic       drain_done;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_proc_mul_issue_ctrl #(.STAGES(STAGES)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_val        (req_val),
        .req_waddr      (req_waddr),
        .req_raddr1     (req_raddr1),
        .req_raddr2     (req_raddr2),
        .req_ren1       (req_ren1),
        .req_ren2       (req_ren2),
        .req_rdy        (req_rdy),
        .mul_fire       (mul_fire),
        .mul_waddr      (mul_waddr),
        .mul_result_val (mul_result_val),
        .mul_result_tag (mul_result_tag),
        .div_wb_val     (div_wb_val),
        .div_wb_tag     (div_wb_tag),
        .div_wb_rdy     (div_wb_rdy),
        .wb_val         (wb_val),
        .wb_waddr       (wb_waddr),
        .wb_sel         (wb_sel),
        .drain_req      (drain_req),
        .drain_done     (drain_done),
        .busy           (busy)
    );

    // Behavioural multiplier: fixed latency, reset by the same signal.
    logic       pipe_val [STAGES];
    logic [4:0] pipe_tag [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe_val[i] <= 1'b0;
                pipe_tag[i] <= 5'd0;
            end
        end else begin
            pipe_val[0] <= mul_fire;
            pipe_tag[0] <= mul_waddr;
            for (int i = 1; i < STAGES; i++) begin
                pipe_val[i] <= pipe_val[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    assign mul_result_val = pipe_val[STAGES-1];
    assign mul_result_tag = pipe_tag[STAGES-1];

    // ---------------------------------------------------------------- checks
    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check5(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------- scoreboard
    typedef struct {
        logic [4:0] tag;
        int         due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (reset_n) begin
            if (wb_val && wb_sel == WB_SEL_MUL) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wb_unexpected: got tag %0d expected no multiplier writeback (cycle %0d)",
                             wb_waddr, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check5("wb_mul_tag", wb_waddr, mon_e.tag);
                    check_int("wb_mul_cycle", cyc, mon_e.due);
                end
            end
            if (mul_fire) begin
                exp_q.push_back('{tag: req_waddr, due: cyc + STAGES});
            end
        end
    end

    // --------------------------------------------------------- stimulus util
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive_req(input logic v, input logic [4:0] wa,
                             input logic r1, input logic [4:0] a1,
                             input logic r2, input logic [4:0] a2);
        req_val    = v;
        req_waddr  = wa;
        req_ren1   = r1;
        req_raddr1 = a1;
        req_ren2   = r2;
        req_raddr2 = a2;
    endtask

    task automatic idle(input int n);
        drive_req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        repeat (n) next_cycle();
    endtask

    // ------------------------------------------------------------ vectors
    typedef struct {
        logic       ren1;
        logic [4:0] ra1;
        logic       ren2;
        logic [4:0] ra2;
        logic [4:0] wa;
        logic       dval;
        logic [4:0] dtag;
        logic       exp_rdy;
        logic       exp_wb_val;
        logic [4:0] exp_wb_waddr;
        logic       exp_wb_sel;
        logic       exp_div_rdy;
    } vec_t;

    vec_t vecs[8];

    task automatic set_vec(input int idx,
                           input logic r1, input logic [4:0] a1,
                           input logic r2, input logic [4:0] a2,
                           input logic [4:0] wa,
                           input logic dv, input logic [4:0] dt,
                           input logic e_rdy, input logic e_wv,
                           input logic [4:0] e_wa, input logic e_ws,
                           input logic e_dr);
        vecs[idx] = '{ren1: r1, ra1: a1, ren2: r2, ra2: a2, wa: wa,
                      dval: dv, dtag: dt, exp_rdy: e_rdy, exp_wb_val: e_wv,
                      exp_wb_waddr: e_wa, exp_wb_sel: e_ws, exp_div_rdy: e_dr};
    endtask

    // Watchdog: the sequence below has a fixed length; this only trips on a hang.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the summary line");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------ sequence
    initial begin
        // Hazard table, applied while pending = {x5, x6} and no result is due.
        set_vec(0, 1'b1, 5'd5, 1'b0, 5'd0, 5'd10, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0);
        set_vec(1, 1'b0, 5'd5, 1'b0, 5'd0, 5'd10, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 1'b0);
        set_vec(2, 1'b0, 5'd0, 1'b1, 5'd6, 5'd10, 1'b0, 5'd3,  1'b0, 1'b0, 5'd3,  1'b1, 1'b0);
        set_vec(3, 1'b1, 5'd7, 1'b0, 5'd6, 5'd10, 1'b0, 5'd3,  1'b1, 1'b0, 5'd3,  1'b1, 1'b0);
        set_vec(4, 1'b0, 5'd0, 1'b0, 5'd0, 5'd6,  1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0);
        set_vec(5, 1'b1, 5'd0, 1'b1, 5'd4, 5'd0,  1'b1, 5'd12, 1'b1, 1'b1, 5'd12, 1'b1, 1'b1);
        set_vec(6, 1'b1, 5'd6, 1'b1, 5'd5, 5'd11, 1'b1, 5'd31, 1'b0, 1'b1, 5'd31, 1'b1, 1'b1);
        set_vec(7, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5,  1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0);

        reset_n    = 1'b0;
        drain_req  = 1'b1;
        div_wb_val = 1'b0;
        div_wb_tag = 5'd0;
        drive_req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);

        // Reset state: req_rdy follows ~drain_req.
        #3;
        check1("reset_rdy_drain", req_rdy, 1'b0);
        drain_req = 1'b0;
        #1;
        check1("reset_rdy", req_rdy, 1'b1);
        check1("reset_busy", busy, 1'b0);
        check1("reset_drain_done", drain_done, 1'b0);
        repeat (2) next_cycle();
        reset_n = 1'b1;

        // ---- Hazard / divider table
        next_cycle();
        drive_req(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        check1("tbl_fire5", mul_fire, 1'b1);
        next_cycle();
        drive_req(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        check1("tbl_fire6", mul_fire, 1'b1);
        next_cycle();
        req_val = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_req(1'b0, vecs[i].wa, vecs[i].ren1, vecs[i].ra1, vecs[i].ren2, vecs[i].ra2);
            div_wb_val = vecs[i].dval;
            div_wb_tag = vecs[i].dtag;
            #1;
            check1($sformatf("tbl%0d_rdy", i), req_rdy, vecs[i].exp_rdy);
            check1($sformatf("tbl%0d_wb_val", i), wb_val, vecs[i].exp_wb_val);
            check5($sformatf("tbl%0d_wb_waddr", i), wb_waddr, vecs[i].exp_wb_waddr);
            check1($sformatf("tbl%0d_wb_sel", i), wb_sel, vecs[i].exp_wb_sel);
            check1($sformatf("tbl%0d_div_rdy", i), div_wb_rdy, vecs[i].exp_div_rdy);
        end
        div_wb_val = 1'b0;
        div_wb_tag = 5'd0;
        idle(STAGES + 2);

        // ---- RAW stall: x5 written in c0, read by the next request
        drive_req(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        check1("raw_c0_rdy", req_rdy, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            drive_req(1'b1, 5'd11, 1'b1, 5'd5, 1'b0, 5'd0);
            settle();
            check1($sformatf("raw_c%0d_rdy", c), req_rdy, 1'b0);
            if (c == 3) begin
                check1("raw_c3_wb_val", wb_val, 1'b1);
                check5("raw_c3_wb_waddr", wb_waddr, 5'd5);
                check1("raw_c3_wb_sel", wb_sel, WB_SEL_MUL);
            end
        end
        next_cycle();
        settle();
        check1("raw_c4_rdy", req_rdy, 1'b1);
        check1("raw_c4_fire", mul_fire, 1'b1);
        next_cycle();
        idle(STAGES + 2);

        // ---- x0 never stalls
        drive_req(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        check1("x0_c0_fire", mul_fire, 1'b1);
        next_cycle();
        drive_req(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        settle();
        check1("x0_c1_rdy", req_rdy, 1'b1);
        next_cycle();
        drive_req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        next_cycle();
        settle();
        check1("x0_c3_wb_val", wb_val, 1'b1);
        check5("x0_c3_wb_waddr", wb_waddr, 5'd0);
        idle(STAGES + 2);

        // ---- Multiplier beats divider on the write port
        drive_req(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
        next_cycle();
        idle(2);
        div_wb_val = 1'b1;
        div_wb_tag = 5'd9;
        settle();
        check5("arb_c3_wb_waddr", wb_waddr, 5'd7);
        check1("arb_c3_wb_sel", wb_sel, WB_SEL_MUL);
        check1("arb_c3_div_rdy", div_wb_rdy, 1'b0);
        next_cycle();
        settle();
        check1("arb_c4_wb_val", wb_val, 1'b1);
        check5("arb_c4_wb_waddr", wb_waddr, 5'd9);
        check1("arb_c4_wb_sel", wb_sel, WB_SEL_DIV);
        check1("arb_c4_div_rdy", div_wb_rdy, 1'b1);
        next_cycle();
        div_wb_val = 1'b0;
        div_wb_tag = 5'd0;
        idle(STAGES + 1);

        // ---- Drain with three multiplies in flight
        for (int c = 0; c < 3; c++) begin
            drive_req(1'b1, 5'(c + 1), 1'b0, 5'd0, 1'b0, 5'd0);
            settle();
            check1($sformatf("drn_c%0d_fire", c), mul_fire, 1'b1);
            next_cycle();
        end
        drive_req(1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
        drain_req = 1'b1;
        settle();
        check1("drn_c3_rdy", req_rdy, 1'b0);
        check1("drn_c3_fire", mul_fire, 1'b0);
        check_int("drn_c3_inflight", int'(dut.inflight_q), 3);
        check1("drn_c3_busy", busy, 1'b1);
        for (int c = 4; c <= 7; c++) begin
            next_cycle();
            settle();
            check1($sformatf("drn_c%0d_busy", c), busy, c <= 5);
            check1($sformatf("drn_c%0d_done", c), drain_done, c == 7);
        end
        check1("drn_c7_rdy", req_rdy, 1'b0);
        next_cycle();
        drain_req = 1'b0;
        settle();
        check1("drn_c8_done", drain_done, 1'b1);
        check1("drn_c8_rdy", req_rdy, 1'b0);
        next_cycle();
        settle();
        check1("drn_c9_done", drain_done, 1'b0);
        check1("drn_c9_fire", mul_fire, 1'b1);
        next_cycle();
        idle(STAGES + 2);

        // ---- Drain with nothing in flight: done in d+2
        drain_req = 1'b1;
        settle();
        check1("drn0_d0_rdy", req_rdy, 1'b0);
        next_cycle();
        settle();
        check1("drn0_d1_done", drain_done, 1'b0);
        next_cycle();
        settle();
        check1("drn0_d2_done", drain_done, 1'b1);
        next_cycle();
        drain_req = 1'b0;
        next_cycle();
        settle();
        check1("drn0_exit_done", drain_done, 1'b0);

        // ---- Drain abandoned while in DRAIN returns to RUN
        drive_req(1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0);
        next_cycle();
        drive_req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        drain_req = 1'b1;
        next_cycle();
        drain_req = 1'b0;
        drive_req(1'b1, 5'd13, 1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        check1("abort_drain_rdy", req_rdy, 1'b0);
        next_cycle();
        settle();
        check1("abort_run_fire", mul_fire, 1'b1);
        check1("abort_done", drain_done, 1'b0);
        next_cycle();
        idle(STAGES + 2);

        // ---- WAW stall on x3
        drive_req(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            settle();
            check1($sformatf("waw_c%0d_rdy", c), req_rdy, 1'b0);
        end
        next_cycle();
        settle();
        check1("waw_c4_fire", mul_fire, 1'b1);
        next_cycle();
        idle(STAGES + 2);

        // ---- Reset mid-stream with two multiplies in flight
        drive_req(1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0);
        next_cycle();
        drive_req(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
        next_cycle();
        drive_req(1'b0, 5'd10, 1'b1, 5'd8, 1'b0, 5'd0);
        settle();
        check1("rst_mid_busy_before", busy, 1'b1);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check1("rst_mid_busy", busy, 1'b0);
        check1("rst_mid_drain_done", drain_done, 1'b0);
        check_int("rst_mid_pending", int'(dut.u_scoreboard.pending_q), 0);
        check1("rst_mid_rdy", req_rdy, 1'b1);
        next_cycle();
        reset_n = 1'b1;
        req_val = 1'b1;
        settle();
        check1("rst_mid_reissue", mul_fire, 1'b1);
        next_cycle();
        idle(STAGES + 3);

        check_int("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_riscv_proc_mul_issue_ctrl
